// File: rtl/decode_pipe_pkg.sv
// ============================================================================
// Module      : decode_pipe_pkg
// Description : Field positions, widths and shared types for the decode stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pipe_pkg;

   localparam int DATA_W = 32;
   localparam int REG_N  = 32;
   localparam int REG_AW = 5;
   localparam int IDEX_W = 8;

   // Instruction field bit positions
   localparam int OP_HI    = 31;
   localparam int OP_LO    = 26;
   localparam int RS_HI    = 25;
   localparam int RS_LO    = 21;
   localparam int RT_HI    = 20;
   localparam int RT_LO    = 16;
   localparam int RD_HI    = 15;
   localparam int RD_LO    = 11;
   localparam int IMM_HI   = 15;
   localparam int IMM_LO   = 0;
   localparam int JMP_HI   = 25;
   localparam int JMP_LO   = 0;
   localparam int FUNCT_HI = 5;
   localparam int FUNCT_LO = 0;

   // IdEx control bundle bit positions
   localparam int IDEX_WBMEM_HI = 7;
   localparam int IDEX_WBMEM_LO = 4;
   localparam int IDEX_MEMREAD  = 5;
   localparam int IDEX_REGDST   = 3;
   localparam int IDEX_ALUOP_HI = 2;
   localparam int IDEX_ALUOP_LO = 1;
   localparam int IDEX_ALUSRC   = 0;

   typedef struct packed {
      logic [IDEX_W-1:0] ctrl;
      logic [DATA_W-1:0] rd1;
      logic [DATA_W-1:0] rd2;
      logic [DATA_W-1:0] sign;
      logic [REG_AW-1:0] rs;
      logic [REG_AW-1:0] rt;
      logic [REG_AW-1:0] rd;
   } id_ex_t;

endpackage

`default_nettype wire

// File: rtl/decode_pipe_id_ex_reg.sv
// ============================================================================
// Module      : id_ex_reg
// Description : ID/EX pipeline register, loads every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_reg
   import decode_pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  id_ex_t i_data,
   output id_ex_t o_data
);

   id_ex_t data_q, data_d;

   always_comb begin
      data_d = i_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign o_data = data_q;

endmodule

`default_nettype wire

// File: rtl/decode_pipe_if_id_reg.sv
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register holding PC and instruction word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_reg
   import decode_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_write,
   input  logic              i_flush,
   input  logic [DATA_W-1:0] i_pc,
   input  logic [DATA_W-1:0] i_instr,
   output logic [DATA_W-1:0] o_pc,
   output logic [DATA_W-1:0] o_instr
);

   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] instr_q, instr_d;

   // Flush beats a stall so a squashed slot never survives as a held instruction
   always_comb begin
      pc_d    = pc_q;
      instr_d = instr_q;
      if (i_flush) begin
         pc_d    = '0;
         instr_d = '0;
      end else if (i_write) begin
         pc_d    = i_pc;
         instr_d = i_instr;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= '0;
         instr_q <= '0;
      end else begin
         pc_q    <= pc_d;
         instr_q <= instr_d;
      end
   end

   assign o_pc    = pc_q;
   assign o_instr = instr_q;

endmodule

`default_nettype wire

// File: rtl/decode_pipe_reg_file.sv
// ============================================================================
// Module      : reg_file
// Description : 32x32 register file, r0 hard-wired to zero, write-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file
   import decode_pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_we,
   input  logic [REG_AW-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [REG_AW-1:0] i_raddr1,
   input  logic [REG_AW-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] regs_q [REG_N];
   logic [DATA_W-1:0] regs_d [REG_N];
   logic              w_write_en;

   assign w_write_en = i_we && (i_waddr != '0);

   always_comb begin
      regs_d = regs_q;
      if (w_write_en) begin
         regs_d[i_waddr] = i_wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // The in-flight write is forwarded so WB and ID can share a cycle
   assign o_rdata1 = (i_raddr1 == '0)                      ? '0      :
                     (w_write_en && i_waddr == i_raddr1)   ? i_wdata :
                                                             regs_q[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0)                      ? '0      :
                     (w_write_en && i_waddr == i_raddr2)   ? i_wdata :
                                                             regs_q[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/decode_pipe.sv
// ============================================================================
// Module      : decode_pipe
// Description : MIPS decode slice: IF/ID register, register file, ID/EX register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_pipe
   import decode_pipe_pkg::*;
(
   input  logic               clock,
   input  logic               reset,
   input  logic               IF_IDwrite,
   input  logic               IF_flush,
   input  logic [DATA_W-1:0]  PCin,
   input  logic [DATA_W-1:0]  instruction,
   input  logic               RegWrite,
   input  logic [REG_AW-1:0]  WriteReg,
   input  logic [DATA_W-1:0]  WriteData,
   input  logic [IDEX_W-1:0]  IdEx,
   input  logic [DATA_W-1:0]  ID_EX_SignIn,
   output logic [DATA_W-1:0]  PCout,
   output logic [25:0]        raJump,
   output logic [3:0]         PC4,
   output logic [5:0]         ControlIn,
   output logic [REG_AW-1:0]  IF_ID_Rs,
   output logic [REG_AW-1:0]  IF_ID_Rt,
   output logic [REG_AW-1:0]  IF_ID_Rd,
   output logic [15:0]        Immi,
   output logic [DATA_W-1:0]  ReadData1,
   output logic [DATA_W-1:0]  ReadData2,
   output logic [3:0]         WB_MEM,
   output logic [1:0]         ALUOp,
   output logic               ID_EX_MemRead,
   output logic               RegDst,
   output logic               ALUSrc,
   output logic [DATA_W-1:0]  ID_EX_ReadOut1,
   output logic [DATA_W-1:0]  ID_EX_ReadOut2,
   output logic [DATA_W-1:0]  ID_EX_SignOut,
   output logic [5:0]         ALUControl,
   output logic [REG_AW-1:0]  ID_EX_Rs,
   output logic [REG_AW-1:0]  ID_EX_Rt,
   output logic [REG_AW-1:0]  ID_EX_Rd
);

   logic [DATA_W-1:0] w_ifid_pc;
   logic [DATA_W-1:0] w_ifid_instr;
   id_ex_t            w_idex_d;
   id_ex_t            w_idex_q;

   if_id_reg u_if_id (
      .clk     (clock),
      .rst     (reset),
      .i_write (IF_IDwrite),
      .i_flush (IF_flush),
      .i_pc    (PCin),
      .i_instr (instruction),
      .o_pc    (w_ifid_pc),
      .o_instr (w_ifid_instr)
   );

   assign PCout     = w_ifid_pc;
   assign PC4       = w_ifid_pc[DATA_W-1:DATA_W-4];
   assign raJump    = w_ifid_instr[JMP_HI:JMP_LO];
   assign ControlIn = w_ifid_instr[OP_HI:OP_LO];
   assign IF_ID_Rs  = w_ifid_instr[RS_HI:RS_LO];
   assign IF_ID_Rt  = w_ifid_instr[RT_HI:RT_LO];
   assign IF_ID_Rd  = w_ifid_instr[RD_HI:RD_LO];
   assign Immi      = w_ifid_instr[IMM_HI:IMM_LO];

   reg_file u_reg_file (
      .clk      (clock),
      .rst      (reset),
      .i_we     (RegWrite),
      .i_waddr  (WriteReg),
      .i_wdata  (WriteData),
      .i_raddr1 (IF_ID_Rs),
      .i_raddr2 (IF_ID_Rt),
      .o_rdata1 (ReadData1),
      .o_rdata2 (ReadData2)
   );

   always_comb begin
      w_idex_d      = '0;
      w_idex_d.ctrl = IdEx;
      w_idex_d.rd1  = ReadData1;
      w_idex_d.rd2  = ReadData2;
      w_idex_d.sign = ID_EX_SignIn;
      w_idex_d.rs   = IF_ID_Rs;
      w_idex_d.rt   = IF_ID_Rt;
      w_idex_d.rd   = IF_ID_Rd;
   end

   id_ex_reg u_id_ex (
      .clk    (clock),
      .rst    (reset),
      .i_data (w_idex_d),
      .o_data (w_idex_q)
   );

   // MemRead overlaps WB_MEM[1]; both views come from the same stored bit
   assign WB_MEM         = w_idex_q.ctrl[IDEX_WBMEM_HI:IDEX_WBMEM_LO];
   assign ID_EX_MemRead  = w_idex_q.ctrl[IDEX_MEMREAD];
   assign RegDst         = w_idex_q.ctrl[IDEX_REGDST];
   assign ALUOp          = w_idex_q.ctrl[IDEX_ALUOP_HI:IDEX_ALUOP_LO];
   assign ALUSrc         = w_idex_q.ctrl[IDEX_ALUSRC];
   assign ID_EX_ReadOut1 = w_idex_q.rd1;
   assign ID_EX_ReadOut2 = w_idex_q.rd2;
   assign ID_EX_SignOut  = w_idex_q.sign;
   assign ALUControl     = w_idex_q.sign[FUNCT_HI:FUNCT_LO];
   assign ID_EX_Rs       = w_idex_q.rs;
   assign ID_EX_Rt       = w_idex_q.rt;
   assign ID_EX_Rd       = w_idex_q.rd;

endmodule

`default_nettype wire

// File: tb/tb_decode_pipe.sv
// ============================================================================
// Module      : tb_decode_pipe
// Description : Self-checking bench for decode_pipe with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_pipe;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        IF_IDwrite = 1'b0;
   logic        IF_flush = 1'b0;
   logic [31:0] PCin = '0;
   logic [31:0] instruction = '0;
   logic        RegWrite = 1'b0;
   logic [4:0]  WriteReg = '0;
   logic [31:0] WriteData = '0;
   logic [7:0]  IdEx = '0;
   logic [31:0] ID_EX_SignIn = '0;

   logic [31:0] PCout, ReadData1, ReadData2, ID_EX_ReadOut1, ID_EX_ReadOut2, ID_EX_SignOut;
   logic [25:0] raJump;
   logic [3:0]  PC4, WB_MEM;
   logic [5:0]  ControlIn, ALUControl;
   logic [4:0]  IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, ID_EX_Rs, ID_EX_Rt, ID_EX_Rd;
   logic [15:0] Immi;
   logic [1:0]  ALUOp;
   logic        ID_EX_MemRead, RegDst, ALUSrc;

   int checks   = 0;
   int failures = 0;

   decode_pipe dut (
      .clock(clock), .reset(reset), .IF_IDwrite(IF_IDwrite), .IF_flush(IF_flush),
      .PCin(PCin), .instruction(instruction), .RegWrite(RegWrite), .WriteReg(WriteReg),
      .WriteData(WriteData), .IdEx(IdEx), .ID_EX_SignIn(ID_EX_SignIn),
      .PCout(PCout), .raJump(raJump), .PC4(PC4), .ControlIn(ControlIn),
      .IF_ID_Rs(IF_ID_Rs), .IF_ID_Rt(IF_ID_Rt), .IF_ID_Rd(IF_ID_Rd), .Immi(Immi),
      .ReadData1(ReadData1), .ReadData2(ReadData2), .WB_MEM(WB_MEM), .ALUOp(ALUOp),
      .ID_EX_MemRead(ID_EX_MemRead), .RegDst(RegDst), .ALUSrc(ALUSrc),
      .ID_EX_ReadOut1(ID_EX_ReadOut1), .ID_EX_ReadOut2(ID_EX_ReadOut2),
      .ID_EX_SignOut(ID_EX_SignOut), .ALUControl(ALUControl),
      .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Rd(ID_EX_Rd)
   );

   always #5 clock = ~clock;

   // Every output packed in one vector for whole-state comparisons
   logic [288:0] obs_all;
   assign obs_all = {PCout, raJump, PC4, ControlIn, IF_ID_Rs, IF_ID_Rt, IF_ID_Rd, Immi,
                     ReadData1, ReadData2, WB_MEM, ALUOp, ID_EX_MemRead, RegDst, ALUSrc,
                     ID_EX_ReadOut1, ID_EX_ReadOut2, ID_EX_SignOut, ALUControl,
                     ID_EX_Rs, ID_EX_Rt, ID_EX_Rd};

   // Reference model: architectural state of the decode stage
   logic [31:0] m_pc, m_ins, m_r1, m_r2, m_sign;
   logic [31:0] m_regs [32];
   logic [7:0]  m_ctrl;
   logic [4:0]  m_rs, m_rt, m_rd;

   task automatic model_reset();
      m_pc = '0; m_ins = '0; m_r1 = '0; m_r2 = '0; m_sign = '0;
      m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
   endtask

   function automatic logic [31:0] mread(input logic [4:0] a);
      if (a == 5'd0) return 32'd0;
      if (RegWrite && WriteReg == a) return WriteData;
      return m_regs[a];
   endfunction

   function automatic logic [288:0] exp_all();
      return {m_pc, m_ins[25:0], m_pc[31:28], m_ins[31:26], m_ins[25:21], m_ins[20:16],
              m_ins[15:11], m_ins[15:0], mread(m_ins[25:21]), mread(m_ins[20:16]),
              m_ctrl[7:4], m_ctrl[2:1], m_ctrl[5], m_ctrl[3], m_ctrl[0],
              m_r1, m_r2, m_sign, m_sign[5:0], m_rs, m_rt, m_rd};
   endfunction

   // One rising edge: model captures the same inputs the DUT sees, then returns at edge+1
   task automatic tick();
      logic [31:0] n_pc, n_ins, n_r1, n_r2, n_sign;
      logic [7:0]  n_ctrl;
      n_r1 = mread(m_ins[25:21]);
      n_r2 = mread(m_ins[20:16]);
      n_ctrl = IdEx;
      n_sign = ID_EX_SignIn;
      if (IF_flush)        begin n_pc = '0;   n_ins = '0;          end
      else if (IF_IDwrite) begin n_pc = PCin; n_ins = instruction; end
      else                 begin n_pc = m_pc; n_ins = m_ins;       end
      if (RegWrite && WriteReg != 5'd0) m_regs[WriteReg] = WriteData;
      @(posedge clock);
      #1;
      m_ctrl = n_ctrl; m_r1 = n_r1; m_r2 = n_r2; m_sign = n_sign;
      m_rs = m_ins[25:21]; m_rt = m_ins[20:16]; m_rd = m_ins[15:11];
      m_pc = n_pc; m_ins = n_ins;
   endtask

   task automatic test_reset();
      model_reset();
      #1 reset = 1'b1;
      #2;
      checks++; if (obs_all !== exp_all()) begin failures++; $display("FAIL reset_state got=%h exp=%h", obs_all, exp_all()); end
      checks++; if ({ReadData1, ReadData2} !== 64'd0) begin failures++; $display("FAIL reset_reads got=%h exp=0", {ReadData1, ReadData2}); end
      #1 reset = 1'b0;
   endtask

   task automatic test_field_decode();
      IF_IDwrite = 1'b1; IF_flush = 1'b0; PCin = 32'h0; instruction = 32'h20080020;
      IdEx = 8'h0C; ID_EX_SignIn = 32'h20; RegWrite = 1'b0;
      tick();
      checks++; if (ControlIn !== 6'h08) begin failures++; $display("FAIL fd_opcode got=%h exp=08", ControlIn); end
      checks++; if (IF_ID_Rs !== 5'd0) begin failures++; $display("FAIL fd_rs got=%0d exp=0", IF_ID_Rs); end
      checks++; if (IF_ID_Rt !== 5'd8) begin failures++; $display("FAIL fd_rt got=%0d exp=8", IF_ID_Rt); end
      checks++; if (Immi !== 16'h0020) begin failures++; $display("FAIL fd_immi got=%h exp=0020", Immi); end
      checks++; if (raJump !== 26'h0080020) begin failures++; $display("FAIL fd_rajump got=%h exp=0080020", raJump); end
      tick();
      checks++; if (ID_EX_Rt !== 5'd8) begin failures++; $display("FAIL fd_idex_rt got=%0d exp=8", ID_EX_Rt); end
      checks++; if ({RegDst, ALUOp, ALUSrc} !== 4'b1100) begin failures++; $display("FAIL fd_ctrl got=%b exp=1100", {RegDst, ALUOp, ALUSrc}); end
      checks++; if (ALUControl !== 6'b100000) begin failures++; $display("FAIL fd_aluctl got=%b exp=100000", ALUControl); end
      checks++; if (obs_all !== exp_all()) begin failures++; $display("FAIL fd_all got=%h exp=%h", obs_all, exp_all()); end
   endtask

   task automatic test_write_read();
      RegWrite = 1'b1; WriteReg = 5'd16; WriteData = 32'hF0;
      tick();
      RegWrite = 1'b0; instruction = 32'hAC100004;
      tick();
      checks++; if (ReadData2 !== 32'hF0) begin failures++; $display("FAIL wr_read2 got=%h exp=f0", ReadData2); end
      tick();
      checks++; if (ID_EX_ReadOut2 !== 32'hF0) begin failures++; $display("FAIL wr_idex_read2 got=%h exp=f0", ID_EX_ReadOut2); end
   endtask

   task automatic test_bypass_r0();
      RegWrite = 1'b1; WriteReg = 5'd16; WriteData = 32'h55;
      #1;
      checks++; if (ReadData2 !== 32'h55) begin failures++; $display("FAIL bp_bypass got=%h exp=55", ReadData2); end
      tick();
      WriteReg = 5'd0;
      #1;
      checks++; if (ReadData1 !== 32'h0) begin failures++; $display("FAIL bp_r0_bypass got=%h exp=0", ReadData1); end
      tick();
      RegWrite = 1'b0;
      #1;
      checks++; if (ReadData1 !== 32'h0) begin failures++; $display("FAIL bp_r0_store got=%h exp=0", ReadData1); end
      checks++; if (ReadData2 !== 32'h55) begin failures++; $display("FAIL bp_r16_store got=%h exp=55", ReadData2); end
   endtask

   task automatic test_stall_flush();
      IF_IDwrite = 1'b1; PCin = 32'h12345670; instruction = 32'h01098024;
      tick();
      IF_IDwrite = 1'b0; PCin = 32'hDEADBEE0; instruction = 32'hFFFFFFFF;
      tick();
      checks++; if ({PCout, ControlIn, IF_ID_Rd} !== {32'h12345670, 6'd0, 5'd16}) begin failures++; $display("FAIL sf_hold got=%h/%h/%0d exp=12345670/00/16", PCout, ControlIn, IF_ID_Rd); end
      tick();
      checks++; if ({ID_EX_Rs, ID_EX_Rd} !== {5'd8, 5'd16}) begin failures++; $display("FAIL sf_recapture got=%0d/%0d exp=8/16", ID_EX_Rs, ID_EX_Rd); end
      IF_flush = 1'b1;
      tick();
      checks++; if ({PCout, raJump, PC4, ControlIn, Immi} !== 84'd0) begin failures++; $display("FAIL sf_flush got=%h exp=0", {PCout, raJump, PC4, ControlIn, Immi}); end
      IF_flush = 1'b0;
      checks++; if (obs_all !== exp_all()) begin failures++; $display("FAIL sf_all got=%h exp=%h", obs_all, exp_all()); end
   endtask

   task automatic test_pipeline();
      IF_IDwrite = 1'b1; instruction = 32'h01098024;
      tick();
      checks++; if ({IF_ID_Rs, IF_ID_Rt, IF_ID_Rd} !== {5'd8, 5'd9, 5'd16}) begin failures++; $display("FAIL pl_ifid got=%0d/%0d/%0d exp=8/9/16", IF_ID_Rs, IF_ID_Rt, IF_ID_Rd); end
      checks++; if (ID_EX_Rd === 5'd16 && ID_EX_Rs === 5'd8 && ID_EX_Rt === 5'd9) begin failures++; $display("FAIL pl_early got=%0d/%0d/%0d exp=not 8/9/16", ID_EX_Rs, ID_EX_Rt, ID_EX_Rd); end
      instruction = 32'h01098025;
      tick();
      checks++; if ({ID_EX_Rs, ID_EX_Rt, ID_EX_Rd} !== {5'd8, 5'd9, 5'd16}) begin failures++; $display("FAIL pl_idex got=%0d/%0d/%0d exp=8/9/16", ID_EX_Rs, ID_EX_Rt, ID_EX_Rd); end
      checks++; if (Immi !== 16'h8025) begin failures++; $display("FAIL pl_immi got=%h exp=8025", Immi); end
   endtask

   task automatic test_random(input int n);
      for (int i = 0; i < n; i++) begin
         IF_IDwrite   = ($urandom_range(0, 3) != 0);
         IF_flush     = ($urandom_range(0, 7) == 0);
         PCin         = $urandom;
         instruction  = $urandom;
         RegWrite     = $urandom_range(0, 1) == 1;
         WriteReg     = 5'($urandom_range(0, 31));
         WriteData    = $urandom;
         IdEx         = 8'($urandom);
         ID_EX_SignIn = $urandom;
         #1;
         checks++; if (obs_all !== exp_all()) begin failures++; $display("FAIL rnd_all cyc=%0d got=%h exp=%h", i, obs_all, exp_all()); end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      RegWrite = 1'b0;
      #2 reset = 1'b1;
      model_reset();
      #1;
      checks++; if (obs_all !== exp_all()) begin failures++; $display("FAIL mid_reset got=%h exp=%h", obs_all, exp_all()); end
      #1 reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_field_decode();
      test_write_read();
      test_bypass_r0();
      test_stall_flush();
      test_pipeline();
      test_random(300);
      test_reset_midstream();
      test_random(60);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
